// File: rtl/rr_bus_mux_pkg.sv
// Shared types and width helpers for the round-robin tri-state bus mux.
package rr_bus_mux_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_t;

    // Channel count used when a caller does not override N.
    localparam int N_DEFAULT = 4;

    // Width of a channel index / round-robin pointer; never narrower than 1 bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must hold values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping modulo N.
module rr_pick
    import rr_bus_mux_pkg::*;
#(
    parameter  int N     = N_DEFAULT,
    localparam int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    // Walk the ring from the far end back toward ptr+1 so the nearest hit wins.
    always_comb begin
        int k;
        k   = 0;
        any = |req;
        idx = '0;
        for (int i = N; i >= 1; i--) begin
            k = int'(ptr) + i;
            if (k >= N) k = k - N;
            if (req[IDX_W'(k)]) idx = IDX_W'(k);
        end
    end

endmodule

// File: rtl/rr_bus_mux_oe.sv
// N-channel bus mux with registered output enable, round-robin arbitration,
// burst limiting and an enforced high-Z turnaround between bus owners.
module rr_bus_mux_oe
    import rr_bus_mux_pkg::*;
#(
    parameter int W         = 8,
    parameter int N         = 4,
    parameter int MAX_BURST = 4,
    parameter int TURN_CYC  = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] din,
    output logic [N-1:0]   gnt,
    output logic           bus_oe,
    output logic [W-1:0]   bus_q,
    output logic [W-1:0]   bus
);

    localparam int IDX_W = idx_width(N);
    localparam int BC_W  = cnt_width(MAX_BURST);
    localparam int TC_W  = cnt_width(TURN_CYC);

    state_t           state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic [BC_W-1:0]  bcnt, bcnt_n;
    logic [TC_W-1:0]  tcnt, tcnt_n;
    logic [N-1:0]     gnt_n;
    logic             oe_n;
    logic [W-1:0]     q_n;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic             owner_req, others_req, burst_done;

    logic [W-1:0] ch [N];

    for (genvar k = 0; k < N; k++) begin : g_ch
        assign ch[k] = din[k*W +: W];
    end

    rr_pick #(.N(N)) u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // While driving, gnt is the owner's one-hot, so it doubles as the owner mask.
    assign owner_req  = |(req & gnt);
    assign others_req = |(req & ~gnt);
    assign burst_done = (bcnt == BC_W'(MAX_BURST));

    // Next-state and next-output logic; everything holds unless a branch says otherwise.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        bcnt_n  = bcnt;
        tcnt_n  = tcnt;
        gnt_n   = gnt;
        oe_n    = bus_oe;
        q_n     = bus_q;
        case (state)
            IDLE: begin
                if (en && pick_any) begin
                    state_n         = DRIVE;
                    gnt_n           = '0;
                    gnt_n[pick_idx] = 1'b1;
                    oe_n            = 1'b1;
                    q_n             = ch[pick_idx];
                    ptr_n           = pick_idx;
                    bcnt_n          = BC_W'(1);
                end
            end
            DRIVE: begin
                // A single release covers owner drop, disable and burst expiry together.
                if (!owner_req || !en || (burst_done && others_req)) begin
                    state_n = TURN;
                    gnt_n   = '0;
                    oe_n    = 1'b0;
                    tcnt_n  = TC_W'(TURN_CYC);
                end else begin
                    q_n = ch[ptr];
                    if (!burst_done) bcnt_n = bcnt + BC_W'(1);
                end
            end
            TURN: begin
                if (tcnt <= TC_W'(1)) begin
                    state_n = IDLE;
                    tcnt_n  = '0;
                end else begin
                    tcnt_n = tcnt - TC_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                oe_n    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset parks the pointer so channel 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= IDX_W'(N - 1);
            bcnt   <= '0;
            tcnt   <= '0;
            gnt    <= '0;
            bus_oe <= 1'b0;
            bus_q  <= '0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            bcnt   <= bcnt_n;
            tcnt   <= tcnt_n;
            gnt    <= gnt_n;
            bus_oe <= oe_n;
            bus_q  <= q_n;
        end
    end

    assign bus = bus_oe ? bus_q : {W{1'bz}};

endmodule
